// File: rtl/memory_access_stage_pkg.sv
// Shared widths, MEM FSM state encoding and the MEM/WB payload for the memory access stage.
package memory_access_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEST_W = 5;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              en;
        logic [DEST_W-1:0] dest;
        logic              mem_read;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic              misalign;
    } wb_bundle_t;

endpackage

// File: rtl/memory_access_stage_mem_wb_register.sv
// MEM/WB pipeline register: captures the writeback bundle (plus misalign flag) every cycle.
module memory_access_stage_mem_wb_register
    import memory_access_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  wb_bundle_t wb_d,
    output wb_bundle_t wb_q
);

    // Stalls are expressed as bubbles in wb_d, so the register loads unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: drives the data-memory req/ready port, stalls upstream while an access is pending,
// and produces the registered MEM/WB bundle. Optional misaligned-access trap: MEM_ALIGN_CHECK_EN.
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_wb_en,
    input  logic [DEST_W-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_st_value,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_res_mem,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_mem_read,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              misalign_err
);

    mem_state_e state_q, state_d;
    wb_bundle_t wb_d, wb_q;
    logic       memop;
    logic       misalign;
    logic       access;
    logic       is_load;

    // Classify the EXE/MEM entry; a misaligned access (when trapped) never reaches memory.
    always_comb begin
        memop = ex_valid & (ex_mem_read | ex_mem_write);
`ifdef MEM_ALIGN_CHECK_EN
        misalign = memop & (ex_alu_result[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        access  = memop & ~misalign;
        is_load = access & ex_mem_read & ~ex_mem_write;
    end

    assign dmem_we     = ex_mem_write;
    assign dmem_addr   = ex_alu_result[ADDR_W-1:0];
    assign dmem_wdata  = ex_st_value;
    assign alu_res_mem = ex_alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request/stall; the request is killed combinationally by reset.
    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = access & ~dmem_ready;
        case (state_q)
            MEM_IDLE: begin
                dmem_req = access;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req = access;
                if (!access || dmem_ready) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        dmem_req = dmem_req & rst_n;
    end

    // Writeback bundle: a bubble while stalled or when the entry is empty.
    always_comb begin
        wb_d = '0;
        if (ex_valid && !mem_stall) begin
            wb_d.valid      = 1'b1;
            wb_d.en         = ex_wb_en & ~misalign;
            wb_d.dest       = ex_dest;
            wb_d.mem_read   = is_load;
            wb_d.alu_result = ex_alu_result;
            wb_d.mem_data   = is_load ? dmem_rdata : '0;
            wb_d.misalign   = misalign;
        end
    end

    memory_access_stage_mem_wb_register u_mem_wb_register (
        .clk   (clk),
        .rst_n (rst_n),
        .wb_d  (wb_d),
        .wb_q  (wb_q)
    );

    assign wb_valid      = wb_q.valid;
    assign wb_en         = wb_q.en;
    assign wb_dest       = wb_q.dest;
    assign wb_mem_read   = wb_q.mem_read;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_mem_data   = wb_q.mem_data;
    assign misalign_err  = wb_q.misalign;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: directed spec scenarios plus randomized ops.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, ex_mem_read, ex_mem_write, ex_wb_en;
    logic [DEST_W-1:0] ex_dest;
    logic [DATA_W-1:0] ex_alu_result, ex_st_value;
    logic              mem_stall, dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] alu_res_mem;
    logic              wb_valid, wb_en, wb_mem_read, misalign_err;
    logic [DEST_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_alu_result, wb_mem_data;

    typedef struct {
        logic              en;
        logic [DEST_W-1:0] dest;
        logic              mr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] md;
        logic              mis;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_wb_en      (ex_wb_en),
        .ex_dest       (ex_dest),
        .ex_alu_result (ex_alu_result),
        .ex_st_value   (ex_st_value),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .alu_res_mem   (alu_res_mem),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_mem_read   (wb_mem_read),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .misalign_err  (misalign_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one EXE/MEM entry (called at posedge+1), holds it through any stall, and
    // pushes the writeback the stage should produce once the entry leaves MEM.
    task automatic do_op(input bit v, input bit rd, input bit wr, input bit we,
                         input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] s, input int lat, input logic [DATA_W-1:0] rv);
        bit   memop = v && (rd || wr);
        bit   mis   = ALIGN && memop && (a[1:0] != 2'b00);
        bit   acc   = memop && !mis;
        int   c     = 0;
        exp_t e;
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_wb_en = we;
        ex_dest = d; ex_alu_result = a; ex_st_value = s;
        while (1) begin
            dmem_rdata = (acc && c == lat) ? rv : $urandom;
            dmem_ready = acc ? (c == lat) : 1'($urandom % 2);
            #2;
            check("mem_stall", 32'(mem_stall), 32'(acc && c < lat));
            check("dmem_req", 32'(dmem_req), 32'(acc));
            check("alu_res_mem", alu_res_mem, a);
            if (acc) begin
                check("dmem_addr", dmem_addr, a);
                check("dmem_wdata", dmem_wdata, s);
                check("dmem_we", 32'(dmem_we), 32'(wr));
            end
            if (!acc || c == lat) break;
            @(posedge clk); #1;
            c++;
        end
        if (v) begin
            e.en = we && !mis; e.dest = d; e.mr = acc && rd && !wr;
            e.alu = a; e.md = rv; e.mis = mis;
            q.push_back(e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Monitor: every live writeback must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 expected no entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("wb_en", 32'(wb_en), 32'(e.en));
                    check("wb_dest", 32'(wb_dest), 32'(e.dest));
                    check("wb_mem_read", 32'(wb_mem_read), 32'(e.mr));
                    check("wb_alu_result", wb_alu_result, e.alu);
                    check("misalign_err", 32'(misalign_err), 32'(e.mis));
                    if (e.mr) check("wb_mem_data", wb_mem_data, e.md);
                end
            end else if (rst_n === 1'b1) begin
                check("idle_misalign", 32'(misalign_err), 32'(0));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_wb_en = 0;
        ex_dest = '0; ex_alu_result = '0; ex_st_value = '0;
        dmem_ready = 0; dmem_rdata = '0;
        #3;
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_wb_en", 32'(wb_en), 32'(0));
        check("rst_misalign", 32'(misalign_err), 32'(0));
        check("rst_dmem_req", 32'(dmem_req), 32'(0));
        next_cycle();
        rst_n = 1'b1;

        next_cycle(); do_op(1, 0, 0, 1, 5'd3, 32'h10, 32'h0, 0, 32'h0);
        next_cycle(); do_op(1, 1, 0, 1, 5'd7, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        next_cycle(); do_op(1, 0, 1, 0, 5'd0, 32'h80, 32'h1234, 3, 32'h0);
        next_cycle(); do_op(1, 1, 1, 1, 5'd9, 32'h8, 32'hCAFE, 1, 32'h5555);
        next_cycle(); do_op(1, 1, 0, 1, 5'd4, 32'h42, 32'h0, 1, 32'h77);
        next_cycle(); do_op(0, 1, 0, 1, 5'd2, 32'h44, 32'h0, 0, 32'h0);
        next_cycle(); do_op(1, 0, 0, 1, 5'd1, 32'h20, 32'h0, 0, 32'h0);

        // Reset while waiting on memory: request drops at once, no writeback appears.
        next_cycle();
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_wb_en = 1;
        ex_dest = 5'd6; ex_alu_result = 32'h100; dmem_ready = 0;
        #2;
        check("wait_stall", 32'(mem_stall), 32'(1));
        next_cycle();
        check("wait_bubble", 32'(wb_valid), 32'(0));
        rst_n = 1'b0;
        #1;
        check("rstwait_req", 32'(dmem_req), 32'(0));
        check("rstwait_wb_valid", 32'(wb_valid), 32'(0));
        ex_valid = 0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle(); do_op(1, 1, 0, 1, 5'd8, 32'h200, 32'h0, 0, 32'hA5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            bit v, rd, wr, we;
            logic [DATA_W-1:0] a;
            v  = ($urandom % 6) != 0;
            rd = 1'($urandom % 2);
            wr = ($urandom % 3) == 0;
            we = 1'($urandom % 2);
            a  = $urandom;
            if (($urandom % 4) != 0) a[1:0] = 2'b00;
            next_cycle();
            do_op(v, rd, wr, we, 5'($urandom), a, $urandom, int'($urandom % 4), $urandom);
        end

        next_cycle(); ex_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
